fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage feeding the decode stage (Control/Registers/HazardDetection).
//   Owns the PC and talks to instruction memory over a one-outstanding req/ack handshake.
//   Buffers fetched {pc,instr} pairs in a small FIFO acting as the IF/ID register.
//   Honours decode stall (hazard bubble) and branch/jump redirect (flush).
// PARAMETERS
//   RESET_PC    32'h0  fetch address after reset (low 2 bits must be 0)
//   FIFO_DEPTH  4      instruction buffer entries; power of 2, >= 2
// PORTS
//   clk_i           in   1   clock, all state updates on rising edge
//   rst_i           in   1   synchronous active-low reset
//   start_i         in   1   fetch enable; 0 = issue no new requests
//   imem_req_o      out  1   fetch request to instruction memory
//   imem_addr_o     out  32  fetch address, stable while imem_req_o && !imem_ack_i
//   imem_ack_i      in   1   request accepted; imem_instr_i valid this cycle
//   imem_instr_i    in   32  fetched instruction word
//   redirect_i      in   1   taken branch/jump from decode: flush and refetch
//   redirect_pc_i   in   32  new fetch address (bits [1:0] forced to 0)
//   stall_i         in   1   decode stall/bubble; head entry not consumed
//   valid_o         out  1   instr_o/pc_o hold a valid instruction
//   instr_o         out  32  head instruction (32'h0 = NOP when !valid_o)
//   pc_o            out  32  PC of head instruction (32'h0 when !valid_o)
// BEHAVIOUR
//   Reset (rst_i=0 at edge): state IDLE, fetch_pc=RESET_PC, FIFO empty; imem_req_o=0,
//     imem_addr_o=RESET_PC, valid_o=0, instr_o=0, pc_o=0.
//   imem_addr_o = fetch_pc register; imem_req_o = 1 in REQ and DROP only.
//   FSM states: IDLE, REQ (request live), DROP (live request already squashed).
//   IDLE -> REQ: start_i && count<FIFO_DEPTH && !redirect_i.
//   REQ on ack: push {fetch_pc, imem_instr_i}; fetch_pc += 4 (wraps 32'hFFFFFFFC -> 0);
//     stay REQ if start_i && count_next<FIFO_DEPTH, else IDLE. No ack: hold req/addr.
//   Back-to-back acks give 1 instr/cycle; pushed entry visible on outputs next cycle.
//   Pop: valid_o && !stall_i at edge removes head. Push+pop same cycle: count unchanged.
//   Redirect (highest priority): FIFO flushed, same-cycle pop and push discarded,
//     fetch_pc <= {redirect_pc_i[31:2],2'b00}.
//     From REQ without ack -> DROP (req/addr held at old value until ack; data discarded).
//     From REQ with ack, or from IDLE/DROP -> IDLE; fetch resumes next cycle.
//   DROP on ack: discard data, -> IDLE. start_i=0 never aborts a live request.
//   valid_o = (count!=0); outputs driven from FIFO head; zeros when empty.
//   Full FIFO: no new request; live request always has a free slot (entry needs count<DEPTH).
//   stall_i with empty FIFO: no effect.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds out ports perf_fetch_o[31:0] (instructions pushed) and
//     perf_flush_o[31:0] (redirect cycles); both 0 on reset, saturate at 32'hFFFFFFFF.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   Reset, start_i=1, ack every cycle -> pc_o 0,4,8,12 on consecutive cycles, valid_o=1.
//   stall_i=1 for 6 cycles, DEPTH=4 -> 4 entries buffered, imem_req_o=0; release -> in order.
//   Ack delayed 3 cycles -> imem_addr_o and imem_req_o held stable; single push on ack.
//   redirect_i, redirect_pc_i=32'h103 during pending req -> DROP, stale data discarded, next pc_o=32'h100.
//   redirect_i same cycle as ack and pop -> FIFO empty next cycle, fetch_pc=redirect target.
//   RESET_PC=32'hFFFFFFF8, free-run -> pc_o FFFFFFF8, FFFFFFFC, 00000000.
//   rst_i=0 mid-request with FETCH_PERF_EN -> all outputs and counters at reset values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the fetch PC and issues one outstanding
//   request at a time to instruction memory. Fetched {pc, instr} pairs are
//   buffered in a small FIFO that acts as the IF/ID register for decode.
//   Decode can hold the head entry (stall_i) or flush the pipe and refetch
//   from a new address (redirect_i).
//
// Parameters
//   RESET_PC    fetch address after reset (low 2 bits zero)
//   FIFO_DEPTH  instruction buffer entries, power of 2, >= 2
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-low reset
//   start_i        fetch enable; 0 = issue no new requests
//   imem_req_o     fetch request to instruction memory
//   imem_addr_o    fetch address, stable while imem_req_o && !imem_ack_i
//   imem_ack_i     request accepted, imem_instr_i valid this cycle
//   imem_instr_i   fetched instruction word
//   redirect_i     taken branch/jump: flush and refetch
//   redirect_pc_i  new fetch address (bits [1:0] ignored)
//   stall_i        decode stall, head entry not consumed
//   valid_o        head entry valid
//   instr_o        head instruction, 0 when empty
//   pc_o           head PC, 0 when empty
//   perf_fetch_o   (FETCH_PERF_EN) instructions pushed, saturating
//   perf_flush_o   (FETCH_PERF_EN) redirect cycles, saturating
//
// Build option
//   FETCH_PERF_EN  when defined, adds the two performance counters.
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no request outstanding
//   REQ     | request live; ack pushes the fetched word
//   DROP    | request live but squashed by a redirect; ack data discarded
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_flush_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] fetch_pc;
  logic [31:0] hold_addr;
  logic [31:0] redirect_target;

  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic fifo_full;
  logic push;
  logic pop;

  assign redirect_target = redirect_pc_i & ~32'h3;

  // Redirect overrides both push and pop in the same cycle.
  assign fifo_full = (count == DEPTH_C);
  assign push      = (state == ST_REQ) && imem_ack_i && !redirect_i;
  assign pop       = (count != '0) && !stall_i && !redirect_i;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!redirect_i && start_i && !fifo_full) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          // An unacked request cannot be withdrawn; park it in DROP.
          state_next = imem_ack_i ? ST_IDLE : ST_DROP;
        end else if (imem_ack_i) begin
          // Only keep requesting if the next word is guaranteed a slot.
          state_next = (start_i && (count_next != DEPTH_C)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect_i || imem_ack_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    imem_req_o  = (state != ST_IDLE);
    // In DROP the fetch PC already holds the redirect target; the memory
    // still sees the address of the squashed request until it acks.
    imem_addr_o = (state == ST_DROP) ? hold_addr : fetch_pc;
  end

  assign valid_o = (count != '0);
  assign instr_o = valid_o ? fifo_instr[rd_ptr] : 32'h0;
  assign pc_o    = valid_o ? fifo_pc[rd_ptr]    : 32'h0;

  // ---------------- PC and FIFO control ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      if ((state == ST_REQ) && !imem_ack_i) begin
        hold_addr <= fetch_pc;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= imem_instr_i;
    end
  end

`ifdef FETCH_PERF_EN
  // ---------------- performance counters ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_fetch_o <= 32'h0;
      perf_flush_o <= 32'h0;
    end else begin
      if (push && (perf_fetch_o != 32'hFFFF_FFFF)) begin
        perf_fetch_o <= perf_fetch_o + 32'd1;
      end
      if (redirect_i && (perf_flush_o != 32'hFFFF_FFFF)) begin
        perf_flush_o <= perf_flush_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_DROP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ack, redir, stall;
  logic [31:0] instr_in, rpc;
  logic        req, valid;
  logic [31:0] addr, instr_o, pc_o;

  logic        w_rst, w_start, w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_flush, w_perf_fetch, w_perf_flush;
`endif

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_instr_i(instr_in),
    .redirect_i(redir), .redirect_pc_i(rpc), .stall_i(stall),
    .valid_o(valid), .instr_o(instr_o), .pc_o(pc_o)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(perf_fetch), .perf_flush_o(perf_flush)
`endif
  );

  // Second instance exercising the 32-bit PC wrap; memory acks every request.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk_i(clk), .rst_i(w_rst), .start_i(w_start),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_req),
    .imem_instr_i(w_addr ^ 32'h5A5A_5A5A),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(1'b0),
    .valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(w_perf_fetch), .perf_flush_o(w_perf_flush)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  int          m_mode;
  logic [31:0] m_pc, m_hold, m_pf, m_pfl;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] m_addr();
    return (m_mode == M_DROP) ? m_hold : m_pc;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step(input logic r, st, ak, rd, input logic [31:0] rp, input logic sl);
    int pre_size;
    if (!r) begin
      m_mode = M_IDLE; m_pc = 32'h0; m_hold = 32'h0; m_pf = 0; m_pfl = 0;
      m_q.delete();
      return;
    end
    if (rd) begin
      m_pfl = sat_inc(m_pfl);
      if (m_mode == M_REQ && !ak) begin
        m_hold = m_pc;
        m_mode = M_DROP;
      end else begin
        m_mode = M_IDLE;
      end
      m_q.delete();
      m_pc = rp & ~32'h3;
      return;
    end
    pre_size = m_q.size();
    if (pre_size != 0 && !sl) void'(m_q.pop_front());
    case (m_mode)
      M_IDLE: if (st && pre_size < DEPTH) m_mode = M_REQ;
      M_REQ: if (ak) begin
        m_q.push_back('{pc: m_pc, instr: word(m_pc)});
        m_pf = sat_inc(m_pf);
        m_pc = m_pc + 32'd4;
        m_mode = (st && m_q.size() < DEPTH) ? M_REQ : M_IDLE;
      end
      M_DROP: if (ak) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_model();
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    e_instr = e_valid ? m_q[0].instr : 32'h0;
    chk("m_valid", {31'h0, valid}, {31'h0, e_valid});
    chk("m_pc",    pc_o,    e_pc);
    chk("m_instr", instr_o, e_instr);
    chk("m_req",   {31'h0, req}, {31'h0, (m_mode != M_IDLE)});
    chk("m_addr",  addr,    m_addr());
`ifdef FETCH_PERF_EN
    chk("m_perf_fetch", perf_fetch, m_pf);
    chk("m_perf_flush", perf_flush, m_pfl);
`endif
  endtask

  // Inputs applied after a falling edge, model advanced at the rising edge,
  // outputs compared at the next falling edge.
  task automatic cycle(input logic r, st, ak, rd, input logic [31:0] rp, input logic sl);
    rst = r; start = st; ack = ak; redir = rd; rpc = rp; stall = sl;
    instr_in = word(m_addr());
    @(posedge clk);
    model_step(r, st, ak, rd, rp, sl);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic st; logic ak; logic rd; logic [31:0] rp; logic sl;
    logic e_valid; logic [31:0] e_pc; logic e_req; logic [31:0] e_addr;
  } vec_t;
  vec_t vt[14];

  initial begin
    logic ak;
    //                st ak rd rp          sl   valid pc          req addr
    vt[0]  = '{1'b1,1'b0,1'b0,32'h0,  1'b1, 1'b0,32'h0,   1'b1,32'h0};
    vt[1]  = '{1'b1,1'b1,1'b0,32'h0,  1'b1, 1'b1,32'h0,   1'b1,32'h4};
    vt[2]  = '{1'b1,1'b1,1'b0,32'h0,  1'b1, 1'b1,32'h0,   1'b1,32'h8};
    vt[3]  = '{1'b1,1'b1,1'b0,32'h0,  1'b0, 1'b1,32'h4,   1'b1,32'hC};
    vt[4]  = '{1'b1,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h8,   1'b1,32'hC};
    vt[5]  = '{1'b1,1'b0,1'b1,32'h103,1'b1, 1'b0,32'h0,   1'b1,32'hC};
    vt[6]  = '{1'b1,1'b1,1'b0,32'h0,  1'b0, 1'b0,32'h0,   1'b0,32'h100};
    vt[7]  = '{1'b1,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,   1'b1,32'h100};
    vt[8]  = '{1'b1,1'b1,1'b0,32'h0,  1'b1, 1'b1,32'h100, 1'b1,32'h104};
    vt[9]  = '{1'b1,1'b1,1'b1,32'h200,1'b0, 1'b0,32'h0,   1'b0,32'h200};
    vt[10] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,   1'b0,32'h200};
    vt[11] = '{1'b1,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,   1'b1,32'h200};
    vt[12] = '{1'b0,1'b1,1'b0,32'h0,  1'b0, 1'b1,32'h200, 1'b0,32'h204};
    vt[13] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,   1'b0,32'h204};

    w_rst = 1'b0; w_start = 1'b0;
    m_mode = M_IDLE; m_pc = 0; m_hold = 0; m_pf = 0; m_pfl = 0;

    // Reset values.
    do_reset();
    do_reset();
    chk("rst_req",   {31'h0, req},   32'h0);
    chk("rst_addr",  addr,           32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr_o,        32'h0);

    // Directed table.
    foreach (vt[i]) begin
      cycle(1'b1, vt[i].st, vt[i].ak, vt[i].rd, vt[i].rp, vt[i].sl);
      chk($sformatf("vec%0d_valid", i), {31'h0, valid}, {31'h0, vt[i].e_valid});
      chk($sformatf("vec%0d_pc", i),    pc_o,           vt[i].e_pc);
      chk($sformatf("vec%0d_req", i),   {31'h0, req},   {31'h0, vt[i].e_req});
      chk($sformatf("vec%0d_addr", i),  addr,           vt[i].e_addr);
    end

    // Stall for 6 cycles with memory acking: FIFO fills, requests stop.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, (m_mode == M_REQ), 1'b0, 32'h0, 1'b1);
    chk("full_req",   {31'h0, req},   32'h0);
    chk("full_valid", {31'h0, valid}, 32'h1);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_pc", k), pc_o, 32'(k * 4));
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("drain_empty", {31'h0, valid}, 32'h0);

    // Ack delayed 3 cycles: request and address held, single push on ack.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("wait%0d_req", k),  {31'h0, req}, 32'h1);
      chk($sformatf("wait%0d_addr", k), addr,         32'h0);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("late_ack_pc",  pc_o,         32'h0);
    chk("late_ack_req", {31'h0, req}, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("late_ack_single", {31'h0, valid}, 32'h0);

    // Reset in the middle of a request after some activity.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("midrst_req",   {31'h0, req},   32'h0);
    chk("midrst_addr",  addr,           32'h0);
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    chk("midrst_pc",    pc_o,           32'h0);
`ifdef FETCH_PERF_EN
    chk("midrst_perf_fetch", perf_fetch, 32'h0);
    chk("midrst_perf_flush", perf_flush, 32'h0);
`endif

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      ak = (m_mode != M_IDLE) && ($urandom_range(0, 9) < 6);
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), ak,
            ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 2) == 0));
    end

    // PC wrap on the second instance.
    @(negedge clk);
    w_rst = 1'b0; w_start = 1'b0;
    @(negedge clk);
    w_rst = 1'b1; w_start = 1'b1;
    @(negedge clk);
    chk("wrap_first_empty", {31'h0, w_valid}, 32'h0);
    @(negedge clk);
    chk("wrap_pc0",    w_pc,    32'hFFFF_FFF8);
    chk("wrap_instr0", w_instr, 32'hFFFF_FFF8 ^ 32'h5A5A_5A5A);
    @(negedge clk);
    chk("wrap_pc1",    w_pc,    32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc2",    w_pc,    32'h0000_0000);
    chk("wrap_valid",  {31'h0, w_valid}, 32'h1);
    @(negedge clk);
    chk("wrap_pc3",    w_pc,    32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
